// File: rtl/code_entry_fsm.sv
// Keypad code-lock: collects CODE_LEN debounced presses, compares them with the
// secret code, then opens, flags an error, or locks out after repeated failures.
module code_entry_fsm #(
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned OPEN_CYCLES    = 300_000_000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [3:0]            btn_pulse,
    input  logic [2*CODE_LEN-1:0] code_in,
    output logic                  unlocked,
    output logic                  error_pulse,
    output logic                  locked_out,
    output logic [2:0]            digit_count,
    output logic [1:0]            fail_count,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        FAIL    = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    state_t                st;
    logic [31:0]           timer;
    logic [2*CODE_LEN-1:0] digits;
    logic                  press_vld;
    logic [1:0]            press_digit;
    logic                  last_digit;

    assign state = st;

    // Multi-bit or empty pulses are not a press in any state.
    assign press_vld  = $onehot(btn_pulse);
    assign last_digit = (digit_count == 3'(CODE_LEN - 1));

    always_comb begin
        press_digit = 2'd0;
        case (btn_pulse)
            4'b0010: press_digit = 2'd1;
            4'b0100: press_digit = 2'd2;
            4'b1000: press_digit = 2'd3;
            default: press_digit = 2'd0;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            st          <= IDLE;
            timer       <= '0;
            digits      <= '0;
            digit_count <= '0;
            fail_count  <= '0;
            unlocked    <= 1'b0;
            error_pulse <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            error_pulse <= 1'b0;
            case (st)
                IDLE: begin
                    timer <= '0;
                    if (press_vld) begin
                        digits[1:0] <= press_digit;
                        digit_count <= 3'd1;
                        st          <= (CODE_LEN == 1) ? CHECK : ENTRY;
                    end
                end
                ENTRY: begin
                    // A press in the timeout cycle still counts.
                    if (press_vld) begin
                        for (int k = 0; k < CODE_LEN; k++)
                            if (digit_count == 3'(k))
                                digits[2*k +: 2] <= press_digit;
                        digit_count <= digit_count + 3'd1;
                        timer       <= '0;
                        if (last_digit) st <= CHECK;
                    end else if (timer == TIMEOUT_CYCLES - 1) begin
                        st          <= IDLE;
                        timer       <= '0;
                        digits      <= '0;
                        digit_count <= '0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                CHECK: begin
                    timer       <= '0;
                    digit_count <= '0;
                    if (digits == code_in) begin
                        st         <= OPEN;
                        unlocked   <= 1'b1;
                        fail_count <= '0;
                    end else begin
                        st          <= FAIL;
                        error_pulse <= 1'b1;
                        if (fail_count != 2'd3) fail_count <= fail_count + 2'd1;
                    end
                end
                OPEN: begin
                    if (timer == OPEN_CYCLES - 1) begin
                        st       <= IDLE;
                        unlocked <= 1'b0;
                        timer    <= '0;
                        digits   <= '0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                FAIL: begin
                    timer  <= '0;
                    digits <= '0;
                    if ({30'd0, fail_count} >= MAX_FAILS) begin
                        st         <= LOCKOUT;
                        locked_out <= 1'b1;
                    end else begin
                        st <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (timer == LOCKOUT_CYCLES - 1) begin
                        st         <= IDLE;
                        locked_out <= 1'b0;
                        fail_count <= '0;
                        timer      <= '0;
                        digits     <= '0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: begin
                    st          <= IDLE;
                    timer       <= '0;
                    digits      <= '0;
                    digit_count <= '0;
                    unlocked    <= 1'b0;
                    locked_out  <= 1'b0;
                end
            endcase
        end
    end

endmodule
